// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared definitions for the reg_file_n register file.
//   FS_DEC/FS_INC/FS_LOAD/FS_CLR : FunSel operation encodings
//   sel_w(depth)                 : width of a read-port select index
package reg_file_pkg;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    // A single-bit select is kept even for very small files so the port never collapses to zero width.
    function automatic int sel_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sat_counter_reg.sv
// sat_counter_reg: one register of the file with dec/inc/load/clear.
//   clk     : updates on the falling edge
//   rst_n   : asynchronous active-low reset, clears q
//   en      : active-high enable for this edge
//   fun_sel : operation select (FS_* encodings)
//   d       : load data
//   q       : register contents
//   evt     : high for the cycle in which an enabled dec/inc wraps (SAT=0)
//             or is blocked at a limit (SAT=1)
module sat_counter_reg
    import reg_file_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAT   = 0
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       fun_sel,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             evt
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] q_nxt;

    // evt is combinational so the parent's sticky flag captures it on the same edge as the update.
    always_comb begin
        q_nxt = q;
        evt   = 1'b0;
        if (en) begin
            case (fun_sel)
                FS_DEC: begin
                    if (q == '0) begin
                        evt   = 1'b1;
                        q_nxt = (SAT != 0) ? q : ALL_ONES;
                    end else begin
                        q_nxt = q - ONE;
                    end
                end
                FS_INC: begin
                    if (q == ALL_ONES) begin
                        evt   = 1'b1;
                        q_nxt = (SAT != 0) ? q : '0;
                    end else begin
                        q_nxt = q + ONE;
                    end
                end
                FS_LOAD: q_nxt = d;
                default: q_nxt = '0;
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/reg_file_n.sv
// reg_file_n: DEPTH-entry register file with dec/inc/load/clear per register,
// two combinational read ports and sticky per-register wrap/saturation flags.
//   CLK     : state updates on the falling edge
//   RST_N   : asynchronous active-low reset of all registers and flags
//   FunSel  : operation applied to every enabled register
//   RegSel  : active-low per-register enables
//   I       : load data
//   OutASel : read port A index (index >= DEPTH reads 0)
//   OutBSel : read port B index (index >= DEPTH reads 0)
//   FlagClr : clears EvtFlag; an event on the same edge still sets its bit
//   OutA    : register OutASel
//   OutB    : register OutBSel
//   ZeroA   : OutA == 0
//   EvtFlag : sticky event flags, one per register
module reg_file_n
    import reg_file_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    parameter  int SAT   = 0,
    localparam int SELW  = sel_w(DEPTH)
)(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       FunSel,
    input  logic [DEPTH-1:0] RegSel,
    input  logic [WIDTH-1:0] I,
    input  logic [SELW-1:0]  OutASel,
    input  logic [SELW-1:0]  OutBSel,
    input  logic             FlagClr,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic             ZeroA,
    output logic [DEPTH-1:0] EvtFlag
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] evt;

    for (genvar k = 0; k < DEPTH; k++) begin : g_reg
        sat_counter_reg #(
            .WIDTH (WIDTH),
            .SAT   (SAT)
        ) u_reg (
            .clk     (CLK),
            .rst_n   (RST_N),
            .en      (~RegSel[k]),
            .fun_sel (FunSel),
            .d       (I),
            .q       (regs[k]),
            .evt     (evt[k])
        );
    end

    // Indices with no matching register fall through to the zero default.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (OutASel == SELW'(k)) OutA = regs[k];
            if (OutBSel == SELW'(k)) OutB = regs[k];
        end
    end

    assign ZeroA = (OutA == '0);

    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            EvtFlag <= '0;
        end else begin
            EvtFlag <= (EvtFlag & {DEPTH{~FlagClr}}) | evt;
        end
    end

endmodule

// File: tb/tb_reg_file_n.sv
module tb_reg_file_n;

    logic CLK;
    logic RST_N;

    // u0: defaults (WIDTH 8, DEPTH 4, SAT 0)
    logic [1:0]  fs0;
    logic [3:0]  rs0;
    logic [7:0]  i0;
    logic [1:0]  as0, bs0;
    logic        fc0;
    logic [7:0]  oa0, ob0;
    logic        za0;
    logic [3:0]  ev0;

    // u1: SAT 1
    logic [1:0]  fs1;
    logic [3:0]  rs1;
    logic [7:0]  i1;
    logic [1:0]  as1, bs1;
    logic        fc1;
    logic [7:0]  oa1, ob1;
    logic        za1;
    logic [3:0]  ev1;

    // u2: WIDTH 16, DEPTH 6
    logic [1:0]  fs2;
    logic [5:0]  rs2;
    logic [15:0] i2;
    logic [2:0]  as2, bs2;
    logic        fc2;
    logic [15:0] oa2, ob2;
    logic        za2;
    logic [5:0]  ev2;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file_n u0 (
        .CLK(CLK), .RST_N(RST_N), .FunSel(fs0), .RegSel(rs0), .I(i0),
        .OutASel(as0), .OutBSel(bs0), .FlagClr(fc0),
        .OutA(oa0), .OutB(ob0), .ZeroA(za0), .EvtFlag(ev0)
    );

    reg_file_n #(.SAT(1)) u1 (
        .CLK(CLK), .RST_N(RST_N), .FunSel(fs1), .RegSel(rs1), .I(i1),
        .OutASel(as1), .OutBSel(bs1), .FlagClr(fc1),
        .OutA(oa1), .OutB(ob1), .ZeroA(za1), .EvtFlag(ev1)
    );

    reg_file_n #(.WIDTH(16), .DEPTH(6)) u2 (
        .CLK(CLK), .RST_N(RST_N), .FunSel(fs2), .RegSel(rs2), .I(i2),
        .OutASel(as2), .OutBSel(bs2), .FlagClr(fc2),
        .OutA(oa2), .OutB(ob2), .ZeroA(za2), .EvtFlag(ev2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Returns 1 ns after a falling edge, so inputs driven next apply at the following falling edge.
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2 RST_N = 1'b0;
        #1;
        n_tests++; if (oa0 !== 8'h00) begin n_fail++; $display("FAIL rst_oa0 got %h exp 00", oa0); end
        n_tests++; if (ob0 !== 8'h00) begin n_fail++; $display("FAIL rst_ob0 got %h exp 00", ob0); end
        n_tests++; if (za0 !== 1'b1)  begin n_fail++; $display("FAIL rst_za0 got %b exp 1", za0); end
        n_tests++; if (ev0 !== 4'h0)  begin n_fail++; $display("FAIL rst_ev0 got %b exp 0000", ev0); end
        n_tests++; if (ev1 !== 4'h0)  begin n_fail++; $display("FAIL rst_ev1 got %b exp 0000", ev1); end
        n_tests++; if (oa2 !== 16'h0) begin n_fail++; $display("FAIL rst_oa2 got %h exp 0000", oa2); end
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_load();
        rs0 = 4'b1110; fs0 = 2'b10; i0 = 8'hA5; as0 = 2'd0; bs0 = 2'd1;
        tick();
        rs0 = 4'b1111;
        n_tests++; if (oa0 !== 8'hA5) begin n_fail++; $display("FAIL load_oa got %h exp a5", oa0); end
        n_tests++; if (za0 !== 1'b0)  begin n_fail++; $display("FAIL load_za got %b exp 0", za0); end
        for (int k = 1; k < 4; k++) begin
            bs0 = 2'(k);
            #1;
            n_tests++; if (ob0 !== 8'h00) begin n_fail++; $display("FAIL load_other r%0d got %h exp 00", k, ob0); end
        end
        n_tests++; if (ev0 !== 4'b0000) begin n_fail++; $display("FAIL load_ev got %b exp 0000", ev0); end
    endtask

    task automatic test_wrap();
        rs0 = 4'b1110; fs0 = 2'b10; i0 = 8'hFF; as0 = 2'd0;
        tick();
        fs0 = 2'b01;
        tick();
        rs0 = 4'b1111;
        n_tests++; if (oa0 !== 8'h00)   begin n_fail++; $display("FAIL inc_wrap_val got %h exp 00", oa0); end
        n_tests++; if (za0 !== 1'b1)    begin n_fail++; $display("FAIL inc_wrap_za got %b exp 1", za0); end
        n_tests++; if (ev0 !== 4'b0001) begin n_fail++; $display("FAIL inc_wrap_ev got %b exp 0001", ev0); end
        fc0 = 1'b1;
        tick();
        fc0 = 1'b0;
        n_tests++; if (ev0 !== 4'b0000) begin n_fail++; $display("FAIL flagclr got %b exp 0000", ev0); end
        // R0 is 0: decrement wraps to all ones.
        rs0 = 4'b1110; fs0 = 2'b00;
        tick();
        rs0 = 4'b1111;
        n_tests++; if (oa0 !== 8'hFF)   begin n_fail++; $display("FAIL dec_wrap_val got %h exp ff", oa0); end
        n_tests++; if (ev0 !== 4'b0001) begin n_fail++; $display("FAIL dec_wrap_ev got %b exp 0001", ev0); end
        // R1 is 0: its wrap on a FlagClr edge survives while bit 0 clears.
        rs0 = 4'b1101; fs0 = 2'b00; fc0 = 1'b1; as0 = 2'd1;
        tick();
        rs0 = 4'b1111; fc0 = 1'b0;
        n_tests++; if (oa0 !== 8'hFF)   begin n_fail++; $display("FAIL setwins_val got %h exp ff", oa0); end
        n_tests++; if (ev0 !== 4'b0010) begin n_fail++; $display("FAIL setwins_ev got %b exp 0010", ev0); end
        rs0 = 4'b1011; fs0 = 2'b10; i0 = 8'h3C; as0 = 2'd2;
        tick();
        rs0 = 4'b1111;
        n_tests++; if (oa0 !== 8'h3C)   begin n_fail++; $display("FAIL load_r2 got %h exp 3c", oa0); end
        n_tests++; if (ev0 !== 4'b0010) begin n_fail++; $display("FAIL sticky_ev got %b exp 0010", ev0); end
    endtask

    task automatic test_multi();
        rs0 = 4'b0000; fs0 = 2'b11;
        tick();
        fs0 = 2'b01;
        tick();
        tick();
        rs0 = 4'b1111; fs0 = 2'b11;
        as0 = 2'd2; bs0 = 2'd3;
        #1;
        n_tests++; if (oa0 !== 8'h02) begin n_fail++; $display("FAIL multi_r2 got %h exp 02", oa0); end
        n_tests++; if (ob0 !== 8'h02) begin n_fail++; $display("FAIL multi_r3 got %h exp 02", ob0); end
        as0 = 2'd0; bs0 = 2'd1;
        #1;
        n_tests++; if (oa0 !== 8'h02) begin n_fail++; $display("FAIL multi_r0 got %h exp 02", oa0); end
        n_tests++; if (ob0 !== 8'h02) begin n_fail++; $display("FAIL multi_r1 got %h exp 02", ob0); end
        n_tests++; if (ev0 !== 4'b0010) begin n_fail++; $display("FAIL multi_ev got %b exp 0010", ev0); end
        // All enables off: FunSel (clear) must have no effect.
        tick();
        n_tests++; if (oa0 !== 8'h02) begin n_fail++; $display("FAIL hold_r0 got %h exp 02", oa0); end
    endtask

    task automatic test_sat();
        rs1 = 4'b1101; fs1 = 2'b00; as1 = 2'd1; bs1 = 2'd0;
        tick();
        rs1 = 4'b1111;
        n_tests++; if (oa1 !== 8'h00)   begin n_fail++; $display("FAIL sat_dec_val got %h exp 00", oa1); end
        n_tests++; if (ev1 !== 4'b0010) begin n_fail++; $display("FAIL sat_dec_ev got %b exp 0010", ev1); end
        rs1 = 4'b1101; fs1 = 2'b01;
        tick();
        tick();
        tick();
        rs1 = 4'b1111;
        n_tests++; if (oa1 !== 8'h03)   begin n_fail++; $display("FAIL sat_inc3 got %h exp 03", oa1); end
        rs1 = 4'b1110; fs1 = 2'b10; i1 = 8'hFF;
        tick();
        fs1 = 2'b01;
        tick();
        rs1 = 4'b1111;
        n_tests++; if (ob1 !== 8'hFF)   begin n_fail++; $display("FAIL sat_inc_val got %h exp ff", ob1); end
        n_tests++; if (ev1 !== 4'b0011) begin n_fail++; $display("FAIL sat_inc_ev got %b exp 0011", ev1); end
    endtask

    task automatic test_wide();
        as2 = 3'd7; bs2 = 3'd6;
        #1;
        n_tests++; if (oa2 !== 16'h0000) begin n_fail++; $display("FAIL oor_oa got %h exp 0000", oa2); end
        n_tests++; if (za2 !== 1'b1)     begin n_fail++; $display("FAIL oor_za got %b exp 1", za2); end
        rs2 = 6'b011111; fs2 = 2'b10; i2 = 16'h1234; bs2 = 3'd5;
        tick();
        rs2 = 6'b111111;
        n_tests++; if (ob2 !== 16'h1234) begin n_fail++; $display("FAIL wide_r5 got %h exp 1234", ob2); end
        n_tests++; if (oa2 !== 16'h0000) begin n_fail++; $display("FAIL wide_oor7 got %h exp 0000", oa2); end
        as2 = 3'd4;
        #1;
        n_tests++; if (oa2 !== 16'h0000) begin n_fail++; $display("FAIL wide_r4 got %h exp 0000", oa2); end
    endtask

    task automatic test_async_reset();
        rs0 = 4'b1110; fs0 = 2'b10; i0 = 8'hFF; as0 = 2'd0; fc0 = 1'b1;
        tick();
        fc0 = 1'b0; fs0 = 2'b01;
        tick();
        fs0 = 2'b10; i0 = 8'h55;
        tick();
        rs0 = 4'b1111;
        n_tests++; if (oa0 !== 8'h55)   begin n_fail++; $display("FAIL pre_rst_val got %h exp 55", oa0); end
        n_tests++; if (ev0 !== 4'b0001) begin n_fail++; $display("FAIL pre_rst_ev got %b exp 0001", ev0); end
        RST_N = 1'b0;
        #1;
        n_tests++; if (oa0 !== 8'h00)   begin n_fail++; $display("FAIL async_rst_val got %h exp 00", oa0); end
        n_tests++; if (za0 !== 1'b1)    begin n_fail++; $display("FAIL async_rst_za got %b exp 1", za0); end
        n_tests++; if (ev0 !== 4'b0000) begin n_fail++; $display("FAIL async_rst_ev got %b exp 0000", ev0); end
        #1 RST_N = 1'b1;
        rs0 = 4'b1110; fs0 = 2'b01;
        tick();
        rs0 = 4'b1111;
        n_tests++; if (oa0 !== 8'h01)   begin n_fail++; $display("FAIL post_rst_inc got %h exp 01", oa0); end
        n_tests++; if (ev0 !== 4'b0000) begin n_fail++; $display("FAIL post_rst_ev got %b exp 0000", ev0); end
    endtask

    initial begin
        RST_N = 1'b1;
        fs0 = 2'b00; rs0 = 4'b1111; i0 = 8'h00; as0 = 2'd0; bs0 = 2'd0; fc0 = 1'b0;
        fs1 = 2'b00; rs1 = 4'b1111; i1 = 8'h00; as1 = 2'd0; bs1 = 2'd0; fc1 = 1'b0;
        fs2 = 2'b00; rs2 = 6'b111111; i2 = 16'h0; as2 = 3'd0; bs2 = 3'd0; fc2 = 1'b0;
        test_reset();
        test_load();
        test_wrap();
        test_multi();
        test_sat();
        test_wide();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_n.md
REG_FILE_N -- requirements
Module: reg_file_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each register, legal 4..32.
REQ-002 SHALL have parameter DEPTH, default 4: number of registers, legal 2..16.
REQ-003 SHALL have parameter SAT, default 0: 0 = inc/dec wrap modulo 2^WIDTH, 1 = inc/dec saturate.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state updates on the falling edge.
REQ-005 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port FunSel, input, 2 bits: operation select, 00 dec, 01 inc, 10 load, 11 clear.
REQ-007 SHALL have port RegSel, input, DEPTH bits: per-register enable, active-low, bit k selects register k.
REQ-008 SHALL have port I, input, WIDTH bits: load data.
REQ-009 SHALL have port OutASel, input, SELW = max(1, clog2(DEPTH)) bits: read port A index.
REQ-010 SHALL have port OutBSel, input, SELW bits: read port B index.
REQ-011 SHALL have port FlagClr, input, 1 bit: clears all sticky event flags, active-high.
REQ-012 SHALL have port OutA, output, WIDTH bits: contents of register OutASel.
REQ-013 SHALL have port OutB, output, WIDTH bits: contents of register OutBSel.
REQ-014 SHALL have port ZeroA, output, 1 bit: high when OutA equals 0.
REQ-015 SHALL have port EvtFlag, output, DEPTH bits: sticky wrap/saturation flag, one bit per register.

Function
REQ-016 On each falling CLK edge, every register k with RegSel[k]=0 SHALL apply FunSel; register k SHALL hold its value when RegSel[k]=1.
REQ-017 Dec (SAT=0) SHALL compute R-1 mod 2^WIDTH; 0 -> all-ones SHALL set EvtFlag[k].
REQ-018 Inc (SAT=0) SHALL compute R+1 mod 2^WIDTH; all-ones -> 0 SHALL set EvtFlag[k].
REQ-019 With SAT=1, dec at 0 SHALL hold 0, inc at all-ones SHALL hold all-ones, and each such blocked step SHALL set EvtFlag[k].
REQ-020 Load SHALL write I and clear SHALL write 0; neither SHALL affect EvtFlag.
REQ-021 Several enabled registers SHALL receive the same operation in the same edge, each computed from its own value.
REQ-022 OutA, OutB and ZeroA SHALL be combinational from the current register contents, with no write-through: a value written at edge n SHALL be visible after edge n.
REQ-023 A select index >= DEPTH SHALL drive the corresponding output to 0; ZeroA SHALL then be 1.
REQ-024 On an edge with FlagClr=1, all EvtFlag bits SHALL clear, except that an event occurring on that same edge SHALL set its bit (set wins).
REQ-025 EvtFlag bits SHALL be sticky until FlagClr or reset.
REQ-026 FunSel SHALL be don't-care when RegSel is all ones.

Reset
REQ-027 RST_N=0 SHALL immediately force all registers and EvtFlag to 0, independent of CLK; OutA=0, OutB=0, ZeroA=1 while reset is held.
REQ-028 Reset asserted mid-operation SHALL abort that edge's update, and no partial value SHALL remain.
REQ-029 The first update after release SHALL occur on the first falling CLK edge with RST_N=1.

Structure
REQ-030 Package reg_file_pkg SHALL hold the FunSel encodings (FS_DEC, FS_INC, FS_LOAD, FS_CLR) and the SELW derivation function.
REQ-031 Each register SHALL be one instance of sub-module sat_counter_reg (parameters WIDTH, SAT), which outputs a one-cycle event pulse.
REQ-032 reg_file_n SHALL generate DEPTH instances of sat_counter_reg, and SHALL contain the read muxes and the EvtFlag sticky logic.

Verification
REQ-033 Defaults, RegSel=1110, FunSel=10, I=8'hA5, one edge, OutASel=0 -> OutA=8'hA5, ZeroA=0, other registers 0.
REQ-034 SAT=0, R0=8'hFF, inc -> R0=8'h00, EvtFlag=0001; then FlagClr=1 with no enables -> EvtFlag=0000.
REQ-035 SAT=1, R1=0, dec (RegSel=1101) -> R1 stays 0, EvtFlag[1]=1; inc x3 -> R1=3.
REQ-036 RegSel=0000, clear, then inc x2 -> all four registers =2; OutASel=2 and OutBSel=3 both read 2.
REQ-037 WIDTH=16, DEPTH=6, OutASel=7 -> OutA=0, ZeroA=1; R5 load 16'h1234 -> OutBSel=5 reads 16'h1234.
REQ-038 RST_N pulsed low between edges while R0=8'h55, EvtFlag=0001 -> immediately R0=0, EvtFlag=0; the next edge after release applies normally.
